// File: rtl/data_memory_wait.sv
// Data memory with request/ready handshake, programmable wait states and access-error reporting.
// Optional write protection of the low address window is enabled by defining DMEM_WPROT_EN.
module data_memory_wait #(
  parameter int                DATA_W      = 8,
  parameter int                ADDR_W      = 8,
  parameter int                DEPTH       = 256,
  parameter int                WAIT_CYCLES = 1,
  parameter int                IVEC_ADDR   = 1,
  parameter logic [DATA_W-1:0] IVEC_RESET  = '0,
  parameter int                PROT_LIMIT  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              ready,
  output logic              err
);

`ifdef DMEM_WPROT_EN
  localparam bit WPROT = 1'b1;
`else
  localparam bit WPROT = 1'b0;
`endif

  localparam int unsigned       DEPTH_U   = DEPTH;
  localparam int unsigned       PROT_U    = PROT_LIMIT;
  localparam bit                ZERO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [3:0]        CNT_LOAD  = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam logic [ADDR_W-1:0] IVEC_A    = ADDR_W'(IVEC_ADDR);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  typedef logic [DATA_W-1:0] mem_t [DEPTH];

  function automatic mem_t mem_init();
    mem_t m;
    m = '{default: '0};
    m[IVEC_A] = IVEC_RESET;
    return m;
  endfunction

  mem_t mem = mem_init();

  state_t            state, state_nx;
  logic [3:0]        cnt;
  logic              op_rd, op_wr, op_err;
  logic [ADDR_W-1:0] op_addr;
  logic [DATA_W-1:0] op_data;

  logic              req, req_err, accept, commit;
  logic              acc_rd, acc_wr, acc_err;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_data;

  assign req     = mem_read | mem_write;
  assign req_err = (mem_read & mem_write)
                 | (32'(address) >= DEPTH_U)
                 | (WPROT & mem_write & (32'(address) < PROT_U));
  assign accept  = (state == IDLE) && req;

  // With zero wait states the access commits on the accept edge, straight from the live inputs.
  always_comb begin
    if (state == IDLE) begin
      acc_rd   = mem_read;
      acc_wr   = mem_write;
      acc_err  = req_err;
      acc_addr = address;
      acc_data = data_in;
    end else begin
      acc_rd   = op_rd;
      acc_wr   = op_wr;
      acc_err  = op_err;
      acc_addr = op_addr;
      acc_data = op_data;
    end
  end

  assign commit = (accept && ZERO_WAIT) || ((state == WAIT) && (cnt == 4'd0));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (req) state_nx = ZERO_WAIT ? DONE : WAIT;
      WAIT:    if (cnt == 4'd0) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state != IDLE);
    ready = (state == DONE);
    err   = (state == DONE) && op_err;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      data_out     <= '0;
      op_rd        <= 1'b0;
      op_wr        <= 1'b0;
      op_err       <= 1'b0;
      op_addr      <= '0;
      op_data      <= '0;
      mem[IVEC_A]  <= IVEC_RESET;
    end else begin
      if (accept) begin
        op_rd   <= mem_read;
        op_wr   <= mem_write;
        op_err  <= req_err;
        op_addr <= address;
        op_data <= data_in;
        cnt     <= CNT_LOAD;
      end else if ((state == WAIT) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      if (commit && !acc_err) begin
        if (acc_wr) mem[acc_addr] <= acc_data;
        if (acc_rd) data_out <= mem[acc_addr];
      end
    end
  end

endmodule
